// File: rtl/fd_multiciclo.sv
// fd_multiciclo: multicycle RV32/RV64 subset datapath with its own
// FETCH/DECODE/EXEC/MEM/WB sequencer and req/ack memory handshakes.
module fd_multiciclo #(
  parameter int XLEN = 64,
  parameter int I_ADDR_BITS = 6,
  parameter int D_ADDR_BITS = 6,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic                   i_mem_req,
  output logic [I_ADDR_BITS-1:0] i_mem_addr,
  input  logic                   i_mem_ack,
  input  logic [31:0]            i_mem_data,
  output logic                   d_mem_req,
  output logic                   d_mem_we,
  output logic [D_ADDR_BITS-1:0] d_mem_addr,
  output logic [XLEN-1:0]        d_mem_wdata,
  input  logic [XLEN-1:0]        d_mem_rdata,
  input  logic                   d_mem_ack,
  output logic [3:0]             alu_flags,
  output logic                   retire,
  output logic                   halted,
  output logic                   illegal
);
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_ADDI   = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [2:0] F3_MEM    = (XLEN == 64) ? 3'b011 : 3'b010;

  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, HALT} state_t;
  state_t state, next_state;

  logic [31:0]            ir;
  logic [XLEN-1:0]        pc;
  logic [XLEN-1:0]        regs [32];
  logic signed [XLEN-1:0] op_a, op_b, imm;
  logic [XLEN-1:0]        alu_res, load_data;
  logic [3:0]             flags;
  logic                   illegal_q;

  logic [6:0] opcode, funct7;
  logic [2:0] funct3;
  logic [4:0] rd, rs1, rs2;
  logic is_r, is_addi, is_ld, is_sd, is_br, is_jal, is_sub, legal;
  logic signed [XLEN-1:0] imm_dec;

  // Decode is purely a function of IR, which stays stable for the whole instruction.
  always_comb begin
    opcode  = ir[6:0];
    funct3  = ir[14:12];
    funct7  = ir[31:25];
    rd      = ir[11:7];
    rs1     = ir[19:15];
    rs2     = ir[24:20];
    is_r    = 1'b0;
    is_addi = 1'b0;
    is_ld   = 1'b0;
    is_sd   = 1'b0;
    is_br   = 1'b0;
    is_jal  = 1'b0;
    case (opcode)
      OP_R:      is_r = ((funct7 == 7'b0000000) && (funct3 inside {3'b000, 3'b110, 3'b111}))
                     || ((funct7 == 7'b0100000) && (funct3 == 3'b000));
      OP_ADDI:   is_addi = (funct3 == 3'b000);
      OP_LOAD:   is_ld = (funct3 == F3_MEM);
      OP_STORE:  is_sd = (funct3 == F3_MEM);
      OP_BRANCH: is_br = (funct3 inside {3'b000, 3'b001, 3'b100, 3'b101});
      OP_JAL:    is_jal = 1'b1;
      default:   ;
    endcase
    is_sub = is_r && funct7[5];
    legal  = is_r | is_addi | is_ld | is_sd | is_br | is_jal;
    imm_dec = {{(XLEN-12){ir[31]}}, ir[31:20]};
    if (is_sd)
      imm_dec = {{(XLEN-12){ir[31]}}, ir[31:25], ir[11:7]};
    else if (is_br)
      imm_dec = {{(XLEN-13){ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
    else if (is_jal)
      imm_dec = {{(XLEN-21){ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  end

  logic [XLEN-1:0] alu_b, b_eff, alu_out;
  logic [XLEN:0]   sum;
  logic            do_sub, arith;
  logic [3:0]      flags_next;

  // Subtraction is a + ~b + 1 so carry and overflow fall out of the same adder.
  always_comb begin
    do_sub  = is_sub | is_br;
    alu_b   = (is_r | is_br) ? op_b : imm;
    b_eff   = do_sub ? ~alu_b : alu_b;
    sum     = {1'b0, op_a} + {1'b0, b_eff} + {{XLEN{1'b0}}, do_sub};
    alu_out = sum[XLEN-1:0];
    arith   = 1'b1;
    if (is_r && funct3 == 3'b111) begin
      alu_out = op_a & op_b;
      arith   = 1'b0;
    end else if (is_r && funct3 == 3'b110) begin
      alu_out = op_a | op_b;
      arith   = 1'b0;
    end
    flags_next[0] = (alu_out == '0);
    flags_next[1] = alu_out[XLEN-1];
    flags_next[2] = arith && (op_a[XLEN-1] == b_eff[XLEN-1]) && (alu_out[XLEN-1] != op_a[XLEN-1]);
    flags_next[3] = arith && sum[XLEN];
  end

  logic            lt, taken, wb_we;
  logic [XLEN-1:0] pc_plus4, pc_next, wb_data;

  always_comb begin
    lt    = flags[1] ^ flags[2];
    taken = 1'b0;
    case (funct3)
      3'b000:  taken = flags[0];
      3'b001:  taken = !flags[0];
      3'b100:  taken = lt;
      3'b101:  taken = !lt;
      default: taken = 1'b0;
    endcase
    taken    = taken && is_br;
    pc_plus4 = pc + XLEN'(4);
    pc_next  = (is_jal || taken) ? (pc + imm) : pc_plus4;
    wb_data  = is_ld ? load_data : (is_jal ? pc_plus4 : alu_res);
    wb_we    = (is_r | is_addi | is_ld | is_jal) && (rd != 5'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FETCH;
    else        state <= next_state;
  end

  // Request lines are gated by rst_n so they drop the instant reset asserts.
  always_comb begin
    next_state = state;
    i_mem_req  = 1'b0;
    d_mem_req  = 1'b0;
    d_mem_we   = 1'b0;
    retire     = 1'b0;
    halted     = 1'b0;
    case (state)
      FETCH: begin
        i_mem_req = rst_n;
        if (i_mem_ack) next_state = DECODE;
      end
      DECODE: next_state = legal ? EXEC : HALT;
      EXEC:   next_state = (is_ld | is_sd) ? MEM : WB;
      MEM: begin
        d_mem_req = rst_n;
        d_mem_we  = rst_n & is_sd;
        if (d_mem_ack) next_state = WB;
      end
      WB: begin
        retire     = 1'b1;
        next_state = FETCH;
      end
      HALT:    halted = 1'b1;
      default: next_state = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      ir        <= '0;
      op_a      <= '0;
      op_b      <= '0;
      imm       <= '0;
      alu_res   <= '0;
      load_data <= '0;
      flags     <= '0;
      illegal_q <= 1'b0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      case (state)
        FETCH: if (i_mem_ack) ir <= i_mem_data;
        DECODE: begin
          op_a <= regs[rs1];
          op_b <= regs[rs2];
          imm  <= imm_dec;
          if (!legal) illegal_q <= 1'b1;
        end
        EXEC: begin
          alu_res <= alu_out;
          flags   <= flags_next;
        end
        MEM: if (d_mem_ack && is_ld) load_data <= d_mem_rdata;
        WB: begin
          if (wb_we) regs[rd] <= wb_data;
          pc <= pc_next;
        end
        default: ;
      endcase
    end
  end

  assign i_mem_addr  = pc[I_ADDR_BITS-1:0];
  assign d_mem_addr  = alu_res[D_ADDR_BITS-1:0];
  assign d_mem_wdata = op_b;
  assign alu_flags   = flags;
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_fd_multiciclo.sv
// Bench for fd_multiciclo: directed and random programs against an
// instruction-level reference model, with variable-latency memory responders.
module tb_fd_multiciclo;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_mem_req;
  logic [5:0]  i_mem_addr;
  logic        i_mem_ack = 1'b0;
  logic [31:0] i_mem_data = '0;
  logic        d_mem_req, d_mem_we;
  logic [5:0]  d_mem_addr;
  logic [63:0] d_mem_wdata;
  logic [63:0] d_mem_rdata = '0;
  logic        d_mem_ack = 1'b0;
  logic [3:0]  alu_flags;
  logic        retire, halted, illegal;

  fd_multiciclo #(.XLEN(64), .I_ADDR_BITS(6), .D_ADDR_BITS(6), .RESET_PC(64'd0)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_mem_req(i_mem_req), .i_mem_addr(i_mem_addr), .i_mem_ack(i_mem_ack), .i_mem_data(i_mem_data),
    .d_mem_req(d_mem_req), .d_mem_we(d_mem_we), .d_mem_addr(d_mem_addr),
    .d_mem_wdata(d_mem_wdata), .d_mem_rdata(d_mem_rdata), .d_mem_ack(d_mem_ack),
    .alu_flags(alu_flags), .retire(retire), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_ret = 0;
  int i_wait = 0, d_wait = 0;

  logic [31:0] imem [16];
  logic [63:0] dmem [8];
  logic [63:0] ref_dmem [8];
  logic [63:0] ref_x [32];
  logic [63:0] ref_pc;

  logic [5:0]  seen_addr;
  logic [63:0] seen_wdata;
  logic        seen_we;
  int          seen_cycles;
  logic        d_stable;

  logic [3:0]  exp_fl;
  bit          exp_chk_fl, exp_mem, exp_st;
  logic [5:0]  exp_addr;
  logic [63:0] exp_wd;
  int          exp_rd;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Instruction memory: acks after i_wait idle cycles of a held request.
  initial begin
    int cnt = 0;
    forever begin
      @(negedge clk);
      if (i_mem_req) begin
        if (cnt >= i_wait) begin
          i_mem_ack = 1'b1;
          i_mem_data = imem[i_mem_addr[5:2]];
          cnt = 0;
        end else begin
          i_mem_ack = 1'b0;
          cnt++;
        end
      end else begin
        i_mem_ack = 1'b0;
        cnt = 0;
      end
    end
  end

  // Data memory: same handshake, also records what the access looked like.
  initial begin
    int cnt = 0;
    logic [5:0] first_addr = '0;
    forever begin
      @(negedge clk);
      if (d_mem_req) begin
        if (cnt == 0) begin
          first_addr = d_mem_addr;
          d_stable = 1'b1;
        end else if (d_mem_addr != first_addr) begin
          d_stable = 1'b0;
        end
        if (cnt >= d_wait) begin
          d_mem_ack = 1'b1;
          d_mem_rdata = dmem[d_mem_addr[5:3]];
          if (d_mem_we) dmem[d_mem_addr[5:3]] = d_mem_wdata;
          seen_addr = d_mem_addr;
          seen_wdata = d_mem_wdata;
          seen_we = d_mem_we;
          seen_cycles = cnt + 1;
          cnt = 0;
        end else begin
          d_mem_ack = 1'b0;
          cnt++;
        end
      end else begin
        d_mem_ack = 1'b0;
        cnt = 0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input int rs2, input int rs1,
                                        input logic [2:0] f3, input int rd);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_i(input int imm, input int rs1, input logic [2:0] f3,
                                        input int rd, input logic [6:0] op);
    logic [11:0] v = 12'(imm);
    return {v, 5'(rs1), f3, 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_s(input int imm, input int rs2, input int rs1);
    logic [11:0] v = 12'(imm);
    return {v[11:5], 5'(rs2), 5'(rs1), 3'b011, v[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input int imm, input int rs2, input int rs1, input logic [2:0] f3);
    logic [12:0] v = 13'(imm);
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), f3, v[4:1], v[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input int imm, input int rd);
    logic [20:0] v = 21'(imm);
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'b1101111};
  endfunction

  function automatic bit ref_legal(input logic [31:0] ins);
    logic [9:0] f = {ins[31:25], ins[14:12]};
    case (ins[6:0])
      7'b0110011: return f == 10'b0000000_000 || f == 10'b0100000_000 ||
                         f == 10'b0000000_111 || f == 10'b0000000_110;
      7'b0010011: return ins[14:12] == 3'b000;
      7'b0000011, 7'b0100011: return ins[14:12] == 3'b011;
      7'b1100011: return ins[14:12] inside {3'b000, 3'b001, 3'b100, 3'b101};
      7'b1101111: return 1'b1;
      default:    return 1'b0;
    endcase
  endfunction

  // Flag vectors are {carry, overflow, msb, zero}, from unbounded-precision arithmetic.
  function automatic logic [3:0] add_fl(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r = a + b;
    logic signed [64:0] wide = $signed({a[63], a}) + $signed({b[63], b});
    return {r < a, wide[64] != wide[63], r[63], r == 64'd0};
  endfunction

  function automatic logic [3:0] sub_fl(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] r = a - b;
    logic signed [64:0] wide = $signed({a[63], a}) - $signed({b[63], b});
    return {a >= b, wide[64] != wide[63], r[63], r == 64'd0};
  endfunction

  task automatic ref_step();
    logic [31:0] ins = imem[ref_pc[5:2]];
    logic [63:0] a = ref_x[ins[19:15]];
    logic [63:0] b = ref_x[ins[24:20]];
    logic [63:0] imm_i = {{52{ins[31]}}, ins[31:20]};
    logic [63:0] imm_s = {{52{ins[31]}}, ins[31:25], ins[11:7]};
    logic [63:0] imm_b = {{51{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    logic [63:0] imm_j = {{43{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    logic [63:0] res = '0, addr = '0, npc = ref_pc + 64'd4;
    bit wr = 1'b0, tk = 1'b0;
    exp_chk_fl = 1'b1; exp_mem = 1'b0; exp_st = 1'b0; exp_wd = '0;
    exp_rd = int'(ins[11:7]);
    case (ins[6:0])
      7'b0110011: begin
        wr = 1'b1;
        case ({ins[31:25], ins[14:12]})
          10'b0100000_000: begin res = a - b; exp_fl = sub_fl(a, b); end
          10'b0000000_111: begin res = a & b; exp_fl = {2'b00, res[63], res == 0}; end
          10'b0000000_110: begin res = a | b; exp_fl = {2'b00, res[63], res == 0}; end
          default:         begin res = a + b; exp_fl = add_fl(a, b); end
        endcase
      end
      7'b0010011: begin wr = 1'b1; res = a + imm_i; exp_fl = add_fl(a, imm_i); end
      7'b0000011: begin
        wr = 1'b1; addr = a + imm_i; exp_fl = add_fl(a, imm_i); exp_mem = 1'b1;
        res = ref_dmem[addr[5:3]];
      end
      7'b0100011: begin
        addr = a + imm_s; exp_fl = add_fl(a, imm_s); exp_mem = 1'b1; exp_st = 1'b1;
        exp_wd = b; ref_dmem[addr[5:3]] = b;
      end
      7'b1100011: begin
        exp_fl = sub_fl(a, b);
        case (ins[14:12])
          3'b000:  tk = (a == b);
          3'b001:  tk = (a != b);
          3'b100:  tk = ($signed(a) < $signed(b));
          default: tk = ($signed(a) >= $signed(b));
        endcase
        if (tk) npc = ref_pc + imm_b;
      end
      default: begin
        wr = 1'b1; res = ref_pc + 64'd4; npc = ref_pc + imm_j; exp_chk_fl = 1'b0;
      end
    endcase
    exp_addr = addr[5:0];
    if (wr && exp_rd != 0) ref_x[exp_rd] = res;
    ref_pc = npc;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic check_halt();
    int t = 0;
    bit req_seen = 1'b0;
    while (!halted && t < 50) begin
      @(negedge clk);
      t++;
    end
    check_eq("halted", halted, 1);
    check_eq("illegal", illegal, 1);
    repeat (8) begin
      @(negedge clk);
      if (i_mem_req || d_mem_req || retire) req_seen = 1'b1;
    end
    check_eq("activity_in_halt", req_seen, 0);
    check_eq("halt_pc", dut.pc, ref_pc);
  endtask

  task automatic run_prog(input int n_ret, input int iw, input int dw);
    int t;
    bit first = 1'b1;
    i_wait = iw;
    d_wait = dw;
    for (int i = 0; i < 8; i++) ref_dmem[i] = dmem[i];
    for (int i = 0; i < 32; i++) ref_x[i] = '0;
    ref_pc = '0;
    do_reset();
    for (int k = 0; k < n_ret; k++) begin
      if (!ref_legal(imem[ref_pc[5:2]])) begin
        check_halt();
        return;
      end
      t = 0;
      do begin
        @(negedge clk);
        t++;
      end while (!retire && t < 200);
      if (!retire) begin
        check_eq("retire_timeout", 0, 1);
        return;
      end
      ref_step();
      check_eq("illegal_low", illegal, 0);
      if (exp_chk_fl) check_eq("flags", alu_flags, exp_fl);
      if (!first) check_eq("latency", cyc - last_ret, 4 + iw + (exp_mem ? 1 + dw : 0));
      first = 1'b0;
      last_ret = cyc;
      if (exp_mem) begin
        check_eq("d_addr", seen_addr, exp_addr);
        check_eq("d_we", seen_we, exp_st);
        check_eq("d_req_cycles", seen_cycles, dw + 1);
        check_eq("d_addr_stable", d_stable, 1);
        if (exp_st) check_eq("d_wdata", seen_wdata, exp_wd);
      end
      @(posedge clk);
      #1;
      check_eq("pc", dut.pc, ref_pc);
      check_eq($sformatf("x%0d", exp_rd), dut.regs[exp_rd], ref_x[exp_rd]);
    end
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 16; i++) imem[i] = 32'h0000007F;
  endtask

  task automatic gen_random_prog();
    int sel, rd, rs1, rs2, v;
    logic [2:0] f3;
    for (int i = 0; i < 16; i++) begin
      sel = int'($urandom_range(0, 99));
      rd  = int'($urandom_range(0, 7));
      rs1 = int'($urandom_range(0, 7));
      rs2 = int'($urandom_range(0, 7));
      if (sel < 30) begin
        case ($urandom_range(0, 3))
          0:       imem[i] = enc_r(7'h00, rs2, rs1, 3'b000, rd);
          1:       imem[i] = enc_r(7'h20, rs2, rs1, 3'b000, rd);
          2:       imem[i] = enc_r(7'h00, rs2, rs1, 3'b111, rd);
          default: imem[i] = enc_r(7'h00, rs2, rs1, 3'b110, rd);
        endcase
      end else if (sel < 55) begin
        v = int'($urandom_range(0, 4095)) - 2048;
        imem[i] = enc_i(v, rs1, 3'b000, rd, 7'b0010011);
      end else if (sel < 65) begin
        imem[i] = enc_i(8 * int'($urandom_range(0, 7)), 0, 3'b011, rd, 7'b0000011);
      end else if (sel < 75) begin
        imem[i] = enc_s(8 * int'($urandom_range(0, 7)), rs2, 0);
      end else if (sel < 90) begin
        case ($urandom_range(0, 3))
          0:       f3 = 3'b000;
          1:       f3 = 3'b001;
          2:       f3 = 3'b100;
          default: f3 = 3'b101;
        endcase
        imem[i] = enc_b(4 * (int'($urandom_range(0, 8)) - 4), rs2, rs1, f3);
      end else begin
        imem[i] = enc_j(4 * (int'($urandom_range(0, 8)) - 4), rd);
      end
    end
  endtask

  initial begin
    int t;
    for (int i = 0; i < 8; i++) dmem[i] = '0;
    clear_imem();

    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_i_req", i_mem_req, 0);
    check_eq("rst_d_req", d_mem_req, 0);
    check_eq("rst_d_we", d_mem_we, 0);
    check_eq("rst_retire", retire, 0);
    check_eq("rst_halted", halted, 0);
    check_eq("rst_illegal", illegal, 0);
    check_eq("rst_flags", alu_flags, 0);
    check_eq("rst_i_addr", i_mem_addr, 0);
    check_eq("rst_d_addr", d_mem_addr, 0);
    check_eq("rst_d_wdata", d_mem_wdata, 0);

    // addi/addi/add, then an illegal opcode
    clear_imem();
    imem[0] = enc_i(5, 0, 3'b000, 1, 7'b0010011);
    imem[1] = enc_i(-3, 0, 3'b000, 2, 7'b0010011);
    imem[2] = enc_r(7'h00, 2, 1, 3'b000, 3);
    run_prog(10, 0, 0);
    check_eq("progA_x3", dut.regs[3], 64'd2);
    check_eq("progA_pc", dut.pc, 64'd12);

    // flags, overflow and a store/load pair with three data wait cycles
    clear_imem();
    dmem[0] = 64'h7FFF_FFFF_FFFF_FFFF;
    imem[0] = enc_i(-1, 0, 3'b000, 1, 7'b0010011);
    imem[1] = enc_r(7'h20, 1, 1, 3'b000, 2);
    imem[2] = enc_i(0, 0, 3'b011, 3, 7'b0000011);
    imem[3] = enc_i(1, 3, 3'b000, 4, 7'b0010011);
    imem[4] = enc_s(8, 4, 0);
    imem[5] = enc_i(8, 0, 3'b011, 5, 7'b0000011);
    run_prog(10, 0, 3);
    check_eq("progB_x2", dut.regs[2], 64'd0);
    check_eq("progB_x5", dut.regs[5], 64'h8000_0000_0000_0000);

    // jal, untaken bne, backward taken beq
    clear_imem();
    imem[0] = enc_i(7, 0, 3'b000, 5, 7'b0010011);
    imem[1] = enc_j(16, 1);
    imem[5] = enc_b(12, 0, 0, 3'b001);
    imem[6] = enc_b(-8, 5, 5, 3'b000);
    run_prog(10, 1, 0);
    check_eq("progC_x1", dut.regs[1], 64'd8);
    check_eq("progC_pc", dut.pc, 64'd16);

    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 8; i++) dmem[i] = {$urandom, $urandom};
      dmem[0] = 64'h7FFF_FFFF_FFFF_FFFF;
      dmem[1] = 64'h8000_0000_0000_0000;
      gen_random_prog();
      run_prog(30, int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
    end

    // reset asserted while a fetch is waiting
    clear_imem();
    imem[0] = enc_i(16, 0, 3'b011, 2, 7'b0000011);
    i_wait = 20;
    do_reset();
    repeat (3) @(negedge clk);
    check_eq("fetch_wait_req", i_mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("fetch_rst_i_req", i_mem_req, 0);
    check_eq("fetch_rst_pc", dut.pc, 64'd0);
    i_wait = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("fetch_restart_req", i_mem_req, 1);
    check_eq("fetch_restart_addr", i_mem_addr, 0);

    // reset asserted while a load is waiting
    d_wait = 20;
    do_reset();
    t = 0;
    while (!d_mem_req && t < 30) begin
      @(negedge clk);
      t++;
    end
    check_eq("mem_wait_req", d_mem_req, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("mem_rst_d_req", d_mem_req, 0);
    check_eq("mem_rst_i_req", i_mem_req, 0);
    check_eq("mem_rst_pc", dut.pc, 64'd0);
    d_wait = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check_eq("mem_restart_req", i_mem_req, 1);
    run_prog(3, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fd_multiciclo.md
Name: fd_multiciclo

Overview:
- Parametrised successor of the single-phase RV64 dataflow.
- Integrates its own sequencing FSM, so no external control unit is needed; the phase counter is replaced by a real FETCH/DECODE/EXEC/MEM/WB state machine.
- Separates read and write memory buses and adds req/ack handshakes for variable-latency memories.
- Adds XLEN generalisation, branches, jal, real overflow/carry flags, and illegal-opcode halt.

Parameters:
- XLEN, 64, datapath and register width (32 or 64).
- I_ADDR_BITS, 6, instruction memory byte-address width.
- D_ADDR_BITS, 6, data memory byte-address width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset. Asynchronous, active-low.
- i_mem_req  out  1  instruction fetch request.
- i_mem_addr  out  I_ADDR_BITS  fetch address, equal to PC[I_ADDR_BITS-1:0].
- i_mem_ack  in  1  fetch data valid this cycle.
- i_mem_data  in  32  instruction word.
- d_mem_req  out  1  data access request.
- d_mem_we  out  1  1 = store, 0 = load. Valid only while d_mem_req is high.
- d_mem_addr  out  D_ADDR_BITS  ALU result [D_ADDR_BITS-1:0].
- d_mem_wdata  out  XLEN  store data, taken from rs2.
- d_mem_rdata  in  XLEN  load data.
- d_mem_ack  in  1  access complete this cycle.
- alu_flags  out  4  [0] zero, [1] MSB, [2] signed overflow, [3] carry out. Registered in EXEC.
- retire  out  1  one-cycle pulse when an instruction completes.
- halted  out  1  high in HALT.
- illegal  out  1  high in HALT when entered via an unsupported opcode.

Behaviour:
- Reset values: all outputs 0, PC = RESET_PC, IR = 0, x1..x31 = 0, state FETCH.
  - An asserted rst_n mid-transaction drops both req lines immediately.
  - A late ack arriving after reset is ignored.
- Supported instructions:
  - add, sub, and, or (R).
  - addi (I, opcode 0010011, funct3 000).
  - ld (0000011; lw when XLEN = 32).
  - sd (0100011; sw when XLEN = 32).
  - beq, bne, blt, bge (1100011).
  - jal (1101111).
  - Any other opcode or funct combination goes to HALT with illegal = 1.
- FETCH:
  - i_mem_req = 1 and i_mem_addr = PC, both held stable until i_mem_ack.
  - On the ack cycle, latch i_mem_data into IR and go to DECODE.
  - i_mem_req is 0 in the next cycle.
- DECODE:
  - Read rs1 and rs2 into operand registers.
  - Build the immediate: I, S, SB (<<1) or UJ (<<1), sign-extended to XLEN.
  - Illegal opcodes go to HALT.
- EXEC:
  - ALU computes add/sub/and/or. Operand B is rs2 or the immediate.
  - Branches subtract rs1 - rs2.
  - Flags are registered here.
  - Overflow = operands of the same sign give a result of the opposite sign, with the sub case inverting B.
  - blt uses MSB XOR overflow.
  - ld/sd go to MEM; everything else goes to WB.
- MEM:
  - d_mem_req = 1; d_mem_we = 1 for sd.
  - Address and data are held stable until d_mem_ack.
  - On ack, ld captures d_mem_rdata; then go to WB.
- WB:
  - Write rd with the ALU result, the load data, or PC+4 (jal).
  - Writes to x0 are discarded; x0 always reads 0.
  - PC <= PC+imm for jal or a taken branch, else PC+4. Wraps modulo 2^XLEN.
  - retire = 1 for this cycle; then go to FETCH.
- Latency with zero-wait memory (ack in the same cycle as req):
  - ALU, branch and jal: 4 cycles.
  - ld and sd: 5 cycles.
  - Each wait cycle adds 1.
- HALT: terminal until reset. No requests, no register or PC writes.
- Register file: synchronous write in WB, combinational read. XLEN-wide, 32 entries.
- Writes to the same register back-to-back are safe: the FSM is strictly serial, so there are no hazards.

Test Plan:
- Reset, then program `addi x1,x0,5; addi x2,x0,-3; add x3,x1,x2` with zero-wait memory -> x3 = 2, retire every 4th cycle, PC = 12.
- `addi x1,x0,-1` then shift-free `sub x2,x1,x1` -> x2 = 0, alu_flags[0] = 1.
  - XLEN = 64 add of 0x7FFF_FFFF_FFFF_FFFF + 1 -> flag[2] = 1, flag[1] = 1.
- `sd x3,8(x0)` then `ld x4,8(x0)` with 3 wait cycles on d_mem_ack -> d_mem_addr = 8 held 4 cycles, x4 = x3, ld takes 8 cycles total.
- beq with equal operands and imm = -8 -> PC decreases by 8.
  - bne with equal operands -> PC+4.
  - `jal x1,16` at PC = 4 -> x1 = 8, PC = 20.
- Opcode 0x7F fetched -> halted = 1 and illegal = 1 after DECODE; no further i_mem_req.
- rst_n low during FETCH wait and during MEM wait -> req lines 0 immediately, PC = RESET_PC, restart fetch after release.
